div_sequencer: RTL and testbench

Multi-cycle sequencer for the RV32M divide/remainder ops (DIV, DIVU, REM, REMU). It executes them with an iterative radix-2 restoring loop, one quotient bit per cycle, so the single-cycle ALU carries no divider. It sits beside the ALU in the execute stage. The core stalls on in_ready/out_valid through a valid/ready handshake on both sides.

---
 rtl/div_sequencer.sv | 143 ++++++++++++++
 tb/tb_div_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_sequencer.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional DIV_SEQUENCER_EARLY_OUT_EN: divide-by-zero, signed overflow and a=0 finish on the accept edge.
//
// state | meaning
// IDLE  | ready for a request, in_ready high
// CALC  | XLEN shift/subtract iterations
// FIX   | sign correction, special-case forcing, result select
// DONE  | result held until out_ready
module div_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out,
    output logic            busy
);
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t          state;
    logic            op_legal, op_rem;
    logic            q_neg, r_neg, div0, ovf;
    logic [XLEN-1:0] a_q, dvd, dvs, rem;
    logic [CW-1:0]   cnt;

    logic            signed_in, div0_in, ovf_in;
    logic [XLEN-1:0] a_abs, b_abs;
    logic [XLEN:0]   rem_sh, rem_sub;
    logic            ge;
    logic [XLEN-1:0] q_fix, r_fix, fix_val;
    logic            eo_hit;
    logic [XLEN-1:0] eo_val;

    always_comb begin
        signed_in = op[2] & ~op[0];
        a_abs     = (signed_in & a[XLEN-1]) ? -a : a;
        b_abs     = (signed_in & b[XLEN-1]) ? -b : b;
        div0_in   = (b == '0);
        ovf_in    = signed_in & (a == MIN_NEG) & (b == '1);

        // One extra bit keeps the shifted remainder exact for divisors >= 2^(XLEN-1)
        rem_sh  = {rem, dvd[XLEN-1]};
        rem_sub = rem_sh - {1'b0, dvs};
        ge      = (rem_sh >= {1'b0, dvs});

        q_fix = div0 ? '1 : ovf ? MIN_NEG : (q_neg ? -dvd : dvd);
        r_fix = div0 ? a_q : ovf ? '0 : (r_neg ? -rem : rem);
        fix_val = !op_legal ? '0 : (op_rem ? r_fix : q_fix);

        eo_hit = op[2] & (div0_in | ovf_in | (a == '0));
        eo_val = op[1] ? (div0_in ? a : '0)
                       : (div0_in ? '1 : (ovf_in ? MIN_NEG : '0));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out       <= '0;
            op_legal  <= 1'b0;
            op_rem    <= 1'b0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            div0      <= 1'b0;
            ovf       <= 1'b0;
            a_q       <= '0;
            dvd       <= '0;
            dvs       <= '0;
            rem       <= '0;
            cnt       <= '0;
        end else if (flush) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    op_legal <= op[2];
                    op_rem   <= op[1];
                    q_neg    <= signed_in & (a[XLEN-1] ^ b[XLEN-1]);
                    r_neg    <= signed_in & a[XLEN-1];
                    div0     <= div0_in;
                    ovf      <= ovf_in;
                    a_q      <= a;
                    dvd      <= a_abs;
                    dvs      <= b_abs;
                    rem      <= '0;
                    cnt      <= CW'(XLEN);
                    in_ready <= 1'b0;
                    busy     <= 1'b1;
`ifdef DIV_SEQUENCER_EARLY_OUT_EN
                    if (eo_hit) begin
                        out       <= eo_val;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        state <= CALC;
                    end
`else
                    state <= CALC;
`endif
                end
                CALC: begin
                    rem <= ge ? rem_sub[XLEN-1:0] : rem_sh[XLEN-1:0];
                    dvd <= {dvd[XLEN-2:0], ge};
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1))
                        state <= FIX;
                end
                FIX: begin
                    out       <= fix_val;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef DIV_SEQUENCER_EARLY_OUT_EN
    logic unused_eo;
    assign unused_eo = eo_hit ^ (^eo_val);
`endif
endmodule

// File: tb/tb_div_sequencer.sv
// Directed self-checking bench for div_sequencer: results, latency, handshake, flush and reset.
module tb_div_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'b000;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out;
    logic        busy;

    int checks = 0;
    int errors = 0;

`ifdef DIV_SEQUENCER_EARLY_OUT_EN
    localparam int LAT_SPECIAL = 0;
`else
    localparam int LAT_SPECIAL = 33;
`endif
    localparam int LAT_FULL = 33;

    localparam logic [2:0] OP_DIV = 3'b100, OP_DIVU = 3'b101, OP_REM = 3'b110, OP_REMU = 3'b111;

    always #5 clk = ~clk;

    div_sequencer #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out(out), .busy(busy)
    );

    // Issue one op, measure edges after the accept edge until out_valid, then release.
    task automatic run_op(input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb,
                          input logic [31:0] exp, input int exp_lat, input string name);
        int n;
        bit rdy_bad;
        @(negedge clk);
        op = o; a = aa; b = bb; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1; op = OP_DIVU;
        n = 0; rdy_bad = 0;
        while (!out_valid && n < 100) begin
            if (in_ready !== 1'b0) rdy_bad = 1;
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n != exp_lat) begin
            errors++; $display("FAIL %s latency: got %0d expected %0d", name, n, exp_lat);
        end
        checks++;
        if (out !== exp) begin
            errors++; $display("FAIL %s result: got %h expected %h", name, out, exp);
        end
        checks++;
        if (rdy_bad || in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL %s in_ready/busy while working: in_ready=%b busy=%b seen_ready=%0d", name, in_ready, busy, rdy_bad);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL %s release: out_valid=%b in_ready=%b busy=%b expected 0 1 0", name, out_valid, in_ready, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out !== 32'h0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL reset state: out_valid=%b out=%h in_ready=%b busy=%b expected 0 0 1 0", out_valid, out, in_ready, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_unsigned();
        run_op(OP_DIVU, 32'd100, 32'd7, 32'd14, LAT_FULL, "divu_100_7");
        run_op(OP_REMU, 32'd100, 32'd7, 32'd2, LAT_FULL, "remu_100_7");
        run_op(OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 32'h1, LAT_FULL, "divu_big");
        run_op(OP_REMU, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, LAT_FULL, "remu_big");
    endtask

    task automatic test_signed();
        run_op(OP_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, LAT_FULL, "rem_m100_7");
        run_op(OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, LAT_FULL, "div_m100_7");
        run_op(OP_DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, LAT_FULL, "div_100_m7");
        run_op(OP_REM, 32'd100, 32'hFFFF_FFF9, 32'd2, LAT_FULL, "rem_100_m7");
        run_op(OP_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, LAT_FULL, "div_m100_m7");
    endtask

    task automatic test_overflow();
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_SPECIAL, "div_ovf");
        run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, LAT_SPECIAL, "rem_ovf");
    endtask

    task automatic test_div_by_zero();
        run_op(OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, LAT_SPECIAL, "divu_by0");
        run_op(OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, LAT_SPECIAL, "div_by0");
        run_op(OP_REMU, 32'd5, 32'd0, 32'd5, LAT_SPECIAL, "remu_by0");
        run_op(OP_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, LAT_SPECIAL, "rem_m5_by0");
    endtask

    task automatic test_misc_ops();
        run_op(OP_DIV, 32'd0, 32'd7, 32'd0, LAT_SPECIAL, "div_zero_dividend");
        run_op(3'b001, 32'd100, 32'd7, 32'd0, LAT_FULL, "illegal_op");
    endtask

    task automatic test_backpressure();
        int n;
        bit bad;
        @(negedge clk);
        op = OP_DIVU; a = 32'd1000; b = 32'd10; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (out_valid !== 1'b1 || out !== 32'd100) begin
            errors++; $display("FAIL bp_result: out_valid=%b out=%h expected 1 %h", out_valid, out, 32'd100);
        end
        bad = 0;
        in_valid = 1'b1; a = 32'd9; b = 32'd3;
        repeat (10) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || out !== 32'd100 || in_ready !== 1'b0) bad = 1;
        end
        in_valid = 1'b0;
        checks++;
        if (bad) begin
            errors++; $display("FAIL bp_hold: out=%h out_valid=%b in_ready=%b expected %h 1 0", out, out_valid, in_ready, 32'd100);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release: out_valid=%b busy=%b in_ready=%b expected 0 0 1", out_valid, busy, in_ready);
        end
    endtask

    task automatic test_flush();
        bit rose;
        @(negedge clk);
        op = OP_DIVU; a = 32'd100; b = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_calc: busy=%b out_valid=%b in_ready=%b expected 0 0 1", busy, out_valid, in_ready);
        end
        rose = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) rose = 1;
        end
        checks++;
        if (rose) begin
            errors++; $display("FAIL flush_no_result: out_valid rose got 1 expected 0");
        end
        @(negedge clk);
        op = OP_DIVU; a = 32'd50; b = 32'd5; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_beats_valid: busy=%b in_ready=%b expected 0 1", busy, in_ready);
        end
        run_op(OP_DIVU, 32'd9, 32'd3, 32'd3, LAT_FULL, "after_flush_9_3");
    endtask

    task automatic test_reset_mid_op();
        bit rose;
        @(negedge clk);
        op = OP_DIVU; a = 32'd77; b = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (out !== 32'h0 || out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_mid_op: out=%h out_valid=%b busy=%b in_ready=%b expected 0 0 0 1", out, out_valid, busy, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        rose = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || busy !== 1'b0) rose = 1;
        end
        checks++;
        if (rose) begin
            errors++; $display("FAIL reset_no_stale: stale activity got 1 expected 0");
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_overflow();
        test_div_by_zero();
        test_misc_ops();
        test_backpressure();
        test_flush();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
